// File: rtl/adc_offset_capture_pkg.sv
// rtl/adc_offset_capture_pkg.sv - shared FSM encoding, output width and default ADC constants
package adc_offset_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_SHIFT,
        ST_DONE
    } spi_state_e;

    localparam int OUT_W = 32;

    // Defaults of the serial ADC on each channel, also used by its bus-functional model.
    localparam int ADC_DATA_W    = 14;
    localparam int ADC_CLK_DIV   = 2;
    localparam int ADC_CONV_WAIT = 4;

    // Bits needed for a counter that runs 0..n-1.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adc_offset_capture_spi_shift.sv
// rtl/adc_offset_capture_spi_shift.sv - one SPI read frame: CS/SCLK generation and MSB-first capture
module adc_spi_shift
    import adc_offset_capture_pkg::*;
#(
    parameter int DATA_W    = ADC_DATA_W,
    parameter int CLK_DIV   = ADC_CLK_DIV,
    parameter int CONV_WAIT = ADC_CONV_WAIT
) (
    input  logic              i_clock,
    input  logic              i_RESET,
    input  logic              start_i,
    input  logic              sdo_i,
    output logic              cs_n_o,
    output logic              sclk_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] raw_o
);

    localparam int TMR_W = cnt_width((CLK_DIV > CONV_WAIT) ? CLK_DIV : CONV_WAIT);
    localparam int BIT_W = cnt_width(DATA_W);
    localparam logic [TMR_W-1:0] CONV_LAST = TMR_W'(CONV_WAIT - 1);
    localparam logic [TMR_W-1:0] HALF_LAST = TMR_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

    spi_state_e        state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              cs_n_q, cs_n_d;
    logic              sclk_q, sclk_d;

    always_ff @(posedge i_clock or negedge i_RESET) begin
        if (!i_RESET) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        done_o  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_CONV;
                    tmr_d   = '0;
                    cs_n_d  = 1'b0;
                end
            end
            ST_CONV: begin
                if (tmr_q == CONV_LAST) begin
                    state_d = ST_SHIFT;
                    tmr_d   = '0;
                    bit_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (tmr_q == HALF_LAST) begin
                    tmr_d  = '0;
                    sclk_d = !sclk_q;
                    // Capture on the edge that raises SCLK; count bits on the falling edge.
                    if (!sclk_q) begin
                        shift_d = {shift_q[DATA_W-2:0], sdo_i};
                    end else if (bit_q == BIT_LAST) begin
                        state_d = ST_DONE;
                        done_o  = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cs_n_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cs_n_o = cs_n_q;
    assign sclk_o = sclk_q;
    assign busy_o = (state_q != ST_IDLE);
    assign raw_o  = shift_q;

endmodule

// File: rtl/adc_offset_capture.sv
// rtl/adc_offset_capture.sv - periodic ADC read with learned DC offset removal, 32-bit signed output
module adc_offset_capture
    import adc_offset_capture_pkg::*;
#(
    parameter int DATA_W        = ADC_DATA_W,
    parameter int CLK_DIV       = ADC_CLK_DIV,
    parameter int CONV_WAIT     = ADC_CONV_WAIT,
    parameter int CAL_LOG2      = 2,
    parameter int SAMPLE_PERIOD = 80
) (
    input  logic             i_clock,
    input  logic             i_RESET,
    input  logic             i_sdo,
    input  logic             i_cal_req,
    output logic             o_cs_n,
    output logic             o_sclk,
    output logic [OUT_W-1:0] o_data,
    output logic             o_valid,
    output logic             o_cal_done
);

    localparam int CNT_W  = cnt_width(SAMPLE_PERIOD);
    localparam int ACC_W  = DATA_W + CAL_LOG2;
    localparam int CAL_CW = CAL_LOG2 + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [CAL_CW-1:0] CAL_LAST = CAL_CW'((1 << CAL_LOG2) - 1);

    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     pend_q, pend_d;
    logic                     cal_done_q, cal_done_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CAL_CW-1:0]        cal_cnt_q, cal_cnt_d;
    logic signed [DATA_W-1:0] offset_q, offset_d;
    logic [OUT_W-1:0]         data_q, data_d;
    logic                     valid_q, valid_d;

    logic                     spi_busy;
    logic                     spi_done;
    logic [DATA_W-1:0]        spi_raw;
    logic signed [DATA_W-1:0] raw_s;
    logic signed [ACC_W-1:0]  acc_sum;
    logic                     frame_start;

    assign frame_start = (cnt_q == '0) && !spi_busy;
    assign raw_s       = spi_raw;
    assign acc_sum     = acc_q + ACC_W'(raw_s);

    adc_spi_shift #(
        .DATA_W   (DATA_W),
        .CLK_DIV  (CLK_DIV),
        .CONV_WAIT(CONV_WAIT)
    ) u_spi (
        .i_clock(i_clock),
        .i_RESET(i_RESET),
        .start_i(frame_start),
        .sdo_i  (i_sdo),
        .cs_n_o (o_cs_n),
        .sclk_o (o_sclk),
        .busy_o (spi_busy),
        .done_o (spi_done),
        .raw_o  (spi_raw)
    );

    always_ff @(posedge i_clock or negedge i_RESET) begin
        if (!i_RESET) begin
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            cal_done_q <= 1'b0;
            acc_q      <= '0;
            cal_cnt_q  <= '0;
            offset_q   <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            cal_done_q <= cal_done_d;
            acc_q      <= acc_d;
            cal_cnt_q  <= cal_cnt_d;
            offset_q   <= offset_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        cnt_d      = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        pend_d     = pend_q;
        cal_done_d = cal_done_q;
        acc_d      = acc_q;
        cal_cnt_d  = cal_cnt_q;
        offset_d   = offset_q;
        data_d     = data_q;
        valid_d    = 1'b0;

        // A recalibration request only takes effect at a frame boundary; the old offset survives until replaced.
        if (frame_start && (pend_q || i_cal_req)) begin
            pend_d     = 1'b0;
            cal_done_d = 1'b0;
            acc_d      = '0;
            cal_cnt_d  = '0;
        end else if (i_cal_req) begin
            pend_d = 1'b1;
        end

        if (spi_done) begin
            if (!cal_done_q) begin
                acc_d     = acc_sum;
                cal_cnt_d = cal_cnt_q + 1'b1;
                if (cal_cnt_q == CAL_LAST) begin
                    offset_d   = DATA_W'(acc_sum >>> CAL_LOG2);
                    cal_done_d = 1'b1;
                end
            end else begin
                data_d  = OUT_W'(raw_s) - OUT_W'(offset_q);
                valid_d = 1'b1;
            end
        end
    end

    assign o_data     = data_q;
    assign o_valid    = valid_q;
    assign o_cal_done = cal_done_q;

endmodule

// File: tb/tb_adc_offset_capture.sv
// tb/tb_adc_offset_capture.sv - directed bench with ADC model and frame-level reference model
module tb_adc_offset_capture;

    localparam int DW = 14;
    localparam int CD = 2;
    localparam int CW = 4;
    localparam int CL = 2;
    localparam int SP = 80;
    localparam int FRAME_END = CW + 2 * CD * DW;

    logic        i_clock   = 1'b0;
    logic        i_RESET   = 1'b0;
    logic        i_sdo     = 1'b0;
    logic        i_cal_req = 1'b0;
    logic        o_cs_n;
    logic        o_sclk;
    logic [31:0] o_data;
    logic        o_valid;
    logic        o_cal_done;

    adc_offset_capture #(
        .DATA_W(DW), .CLK_DIV(CD), .CONV_WAIT(CW), .CAL_LOG2(CL), .SAMPLE_PERIOD(SP)
    ) dut (
        .i_clock   (i_clock),
        .i_RESET   (i_RESET),
        .i_sdo     (i_sdo),
        .i_cal_req (i_cal_req),
        .o_cs_n    (o_cs_n),
        .o_sclk    (o_sclk),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .o_cal_done(o_cal_done)
    );

    always #5 i_clock = ~i_clock;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic checkb(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s at t=%0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    // Reference model: edge index since reset release decides where in the frame we are.
    int          e = 0;
    bit          pend = 1'b0;
    bit          m_cal_done = 1'b0;
    int          m_sum = 0;
    int          m_n = 0;
    int          m_off = 0;
    int          cur_word = 0;
    logic [31:0] exp_data = '0;
    logic        exp_valid = 1'b0;
    logic        exp_cs_n = 1'b1;
    logic        exp_sclk = 1'b0;

    function automatic int sx(input int w);
        return (w >= (1 << (DW - 1))) ? w - (1 << DW) : w;
    endfunction

    function automatic int floor_div(input int a, input int b);
        return (a >= 0) ? a / b : -((-a + b - 1) / b);
    endfunction

    initial forever begin
        @(posedge i_clock or negedge i_RESET);
        if (!i_RESET) begin
            e = 0; pend = 1'b0; m_cal_done = 1'b0; m_sum = 0; m_n = 0; m_off = 0;
            exp_data = '0; exp_valid = 1'b0; exp_cs_n = 1'b1; exp_sclk = 1'b0;
        end else begin
            int ph;
            ph = e % SP;
            exp_valid = 1'b0;
            if (ph == 0 && (pend || i_cal_req)) begin
                pend = 1'b0; m_cal_done = 1'b0; m_sum = 0; m_n = 0;
            end else if (i_cal_req) begin
                pend = 1'b1;
            end
            if (ph == FRAME_END) begin
                if (!m_cal_done) begin
                    m_sum += sx(cur_word);
                    m_n++;
                    if (m_n == (1 << CL)) begin
                        m_off = floor_div(m_sum, 1 << CL);
                        m_cal_done = 1'b1;
                    end
                end else begin
                    exp_data  = 32'(sx(cur_word) - m_off);
                    exp_valid = 1'b1;
                end
            end
            exp_cs_n = (ph > FRAME_END);
            exp_sclk = (ph >= CW && ph < FRAME_END) ? (((ph - CW) / CD) % 2 == 1) : 1'b0;
            e++;
        end
    end

    initial forever begin
        @(negedge i_clock);
        checkb("cs_n", o_cs_n, exp_cs_n);
        checkb("sclk", o_sclk, exp_sclk);
        checkb("valid", o_valid, exp_valid);
        checkb("cal_done", o_cal_done, m_cal_done);
        check("data", o_data, exp_data);
    end

    // ADC model: word latched at CS fall, next bit presented after each SCLK rise.
    int   wq[$];
    int   bit_idx = 0;
    logic prev_cs = 1'b1;
    logic prev_sclk = 1'b0;

    initial forever begin
        @(negedge i_clock);
        if (prev_cs && !o_cs_n) begin
            cur_word = (wq.size() > 0) ? wq.pop_front() : 0;
            bit_idx  = 0;
        end else if (!prev_sclk && o_sclk) begin
            bit_idx++;
        end
        i_sdo     = (!o_cs_n && bit_idx < DW) ? cur_word[DW - 1 - bit_idx] : 1'b0;
        prev_cs   = o_cs_n;
        prev_sclk = o_sclk;
    end

    // Frame timing monitor.
    int   cs_low_cnt = 0, last_cs_low = 0, rise_cnt = 0, last_rises = 0;
    int   fall_e = 0, last_period = 0, last_rise_e = 0, valid_rise_e = 0, valid_cnt = 0;
    logic mprev_cs = 1'b1, mprev_sclk = 1'b0, mprev_valid = 1'b0;

    initial forever begin
        @(negedge i_clock);
        if (mprev_cs && !o_cs_n) begin
            last_period = e - fall_e;
            fall_e      = e;
            cs_low_cnt  = 0;
            rise_cnt    = 0;
        end
        if (!o_cs_n) cs_low_cnt++;
        if (!mprev_cs && o_cs_n) begin
            last_cs_low = cs_low_cnt;
            last_rises  = rise_cnt;
        end
        if (!o_cs_n && !mprev_sclk && o_sclk) begin
            rise_cnt++;
            last_rise_e = e;
        end
        if (!mprev_valid && o_valid) begin
            valid_rise_e = e;
            valid_cnt++;
        end
        mprev_cs    = o_cs_n;
        mprev_sclk  = o_sclk;
        mprev_valid = o_valid;
    end

    task automatic run_to(input int n);
        int guard;
        guard = 0;
        while (e < n && guard < 4000) begin
            @(negedge i_clock);
            guard++;
        end
        if (e < n) begin
            n_checks++;
            n_fails++;
            $display("FAIL run_to timeout: reached edge %0d, required %0d", e, n);
        end
    endtask

    task automatic pulse_req(input int edge_idx);
        run_to(edge_idx);
        i_cal_req = 1'b1;
        @(negedge i_clock);
        i_cal_req = 1'b0;
    endtask

    initial begin
        int vsnap;
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int vsnap;
        wq = {16, 16, 16, 16, 'h64, 'h3FF0, 'h10, 'h20, 'h20, 'h20, 'h20, 'h64,
              0, 10, 11, 12, 14, 11, 'h64, 'h1234};
        repeat (3) @(negedge i_clock);
        checkb("rst_cs_n", o_cs_n, 1'b1);
        checkb("rst_sclk", o_sclk, 1'b0);
        checkb("rst_valid", o_valid, 1'b0);
        check("rst_data", o_data, 32'h0);
        checkb("rst_cal_done", o_cal_done, 1'b0);
        i_RESET = 1'b1;

        run_to(1);
        checkb("first_edge_cs_low", o_cs_n, 1'b0);
        run_to(301);
        checkb("cal_done_after_4", o_cal_done, 1'b1);
        check("no_valid_during_cal", valid_cnt, 0);
        check("model_off_16", m_off, 16);
        run_to(381);
        checkb("valid_frame4", o_valid, 1'b1);
        check("data_84", o_data, 32'd84);
        run_to(382);
        check("cs_low_cycles", last_cs_low, 61);
        check("sclk_rises", last_rises, 14);
        check("frame_period", last_period, 80);
        check("valid_after_last_capture", valid_rise_e - last_rise_e, CD);
        run_to(461);
        check("data_neg32", o_data, 32'hFFFFFFE0);

        pulse_req(510);
        run_to(541);
        checkb("inflight_valid", o_valid, 1'b1);
        check("inflight_data", o_data, 32'd0);
        run_to(561);
        checkb("recal_clears_done", o_cal_done, 1'b0);
        vsnap = valid_cnt;
        run_to(861);
        check("no_valid_recal", valid_cnt, vsnap);
        check("data_held_recal", o_data, 32'd0);
        check("model_off_32", m_off, 32);
        run_to(941);
        check("data_68", o_data, 32'd68);

        pulse_req(990);
        run_to(1021);
        check("data_neg32_b", o_data, 32'hFFFFFFE0);
        run_to(1421);
        check("model_off_11", m_off, 11);
        checkb("floor_valid", o_valid, 1'b1);
        check("floor_data_0", o_data, 32'd0);
        run_to(1501);
        check("data_89", o_data, 32'd89);

        run_to(1550);
        #2 i_RESET = 1'b0;
        #1;
        checkb("async_rst_cs_n", o_cs_n, 1'b1);
        checkb("async_rst_sclk", o_sclk, 1'b0);
        checkb("async_rst_valid", o_valid, 1'b0);
        check("async_rst_data", o_data, 32'h0);
        checkb("async_rst_cal_done", o_cal_done, 1'b0);
        wq.delete();
        wq = {'h3FFF, 'h3FFE, 'h3FFE, 'h3FFE, 0};
        vsnap = valid_cnt;
        repeat (2) @(negedge i_clock);
        i_RESET = 1'b1;

        run_to(1);
        checkb("post_rst_cs_low", o_cs_n, 1'b0);
        run_to(301);
        check("post_rst_no_valid", valid_cnt, vsnap);
        checkb("post_rst_cal_done", o_cal_done, 1'b1);
        check("model_off_neg2", m_off, -2);
        run_to(381);
        checkb("post_rst_valid", o_valid, 1'b1);
        check("data_2", o_data, 32'd2);
        run_to(390);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
